// File: rtl/dmem_arbiter_if.sv
// Signal bundle for dmem_arbiter: two requester ports plus the data-memory side.
interface dmem_arbiter_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [31:0] req0_addr_i;
  logic [1:0]  req0_byte_en_i;
  logic        req0_wr_i;
  logic [31:0] req0_wr_data_i;
  logic        req0_zero_extnd_i;
  logic        rsp0_valid_o;
  logic        rsp0_err_o;
  logic [31:0] rsp0_rd_data_o;

  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [31:0] req1_addr_i;
  logic [1:0]  req1_byte_en_i;
  logic        req1_wr_i;
  logic [31:0] req1_wr_data_i;
  logic        req1_zero_extnd_i;
  logic        rsp1_valid_o;
  logic        rsp1_err_o;
  logic [31:0] rsp1_rd_data_o;

  logic        dmem_req_o;
  logic [31:0] dmem_addr_o;
  logic [1:0]  dmem_byte_en_o;
  logic        dmem_wr_o;
  logic [31:0] dmem_wr_data_o;
  logic        dmem_zero_extnd_o;
  logic [31:0] dmem_rd_data_i;

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_byte_en_i, req0_wr_i, req0_wr_data_i, req0_zero_extnd_i,
    output req0_ready_o, rsp0_valid_o, rsp0_err_o, rsp0_rd_data_o,
    input  req1_valid_i, req1_addr_i, req1_byte_en_i, req1_wr_i, req1_wr_data_i, req1_zero_extnd_i,
    output req1_ready_o, rsp1_valid_o, rsp1_err_o, rsp1_rd_data_o,
    output dmem_req_o, dmem_addr_o, dmem_byte_en_o, dmem_wr_o, dmem_wr_data_o, dmem_zero_extnd_o,
    input  dmem_rd_data_i
  );

  modport master (
    output req0_valid_i, req0_addr_i, req0_byte_en_i, req0_wr_i, req0_wr_data_i, req0_zero_extnd_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_err_o, rsp0_rd_data_o,
    output req1_valid_i, req1_addr_i, req1_byte_en_i, req1_wr_i, req1_wr_data_i, req1_zero_extnd_i,
    input  req1_ready_o, rsp1_valid_o, rsp1_err_o, rsp1_rd_data_o,
    input  dmem_req_o, dmem_addr_o, dmem_byte_en_o, dmem_wr_o, dmem_wr_data_o, dmem_zero_extnd_o,
    output dmem_rd_data_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of the 4 KB data memory.
// Illegal accesses are answered with an error pulse and never reach the memory.
module dmem_arbiter #(
  parameter int DMEM_WORDS = 1024
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DMEM_WORDS);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic        dmem_req_q, dmem_req_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [1:0]  dmem_byte_en_q, dmem_byte_en_d;
  logic        dmem_wr_q, dmem_wr_d;
  logic [31:0] dmem_wr_data_q, dmem_wr_data_d;
  logic        dmem_zero_extnd_q, dmem_zero_extnd_d;

  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wr_data;
  logic [1:0][1:0]  req_byte_en;
  logic [1:0]       req_wr;
  logic [1:0]       req_zero_extnd;

  assign req_valid      = {bus.req1_valid_i, bus.req0_valid_i};
  assign req_addr       = {bus.req1_addr_i, bus.req0_addr_i};
  assign req_wr_data    = {bus.req1_wr_data_i, bus.req0_wr_data_i};
  assign req_byte_en    = {bus.req1_byte_en_i, bus.req0_byte_en_i};
  assign req_wr         = {bus.req1_wr_i, bus.req0_wr_i};
  assign req_zero_extnd = {bus.req1_zero_extnd_i, bus.req0_zero_extnd_i};

  logic        grant_vld;
  logic        grant_id;
  logic        sel_legal;
  logic [31:0] sel_addr;
  logic [31:0] sel_wr_data;
  logic [1:0]  sel_byte_en;
  logic        sel_wr;
  logic        sel_zero_extnd;

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    grant_vld      = (state_q == IDLE) && (req_valid != 2'b00);
    grant_id       = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    sel_addr       = req_addr[grant_id];
    sel_wr_data    = req_wr_data[grant_id];
    sel_byte_en    = req_byte_en[grant_id];
    sel_wr         = req_wr[grant_id];
    sel_zero_extnd = req_zero_extnd[grant_id];
    sel_legal      = (sel_byte_en != 2'b10)
                  && !((sel_byte_en == 2'b01) && sel_addr[0])
                  && !((sel_byte_en == 2'b11) && (sel_addr[1:0] != 2'b00))
                  && (sel_addr < ADDR_LIMIT);
  end

  assign bus.req0_ready_o = reset_n && grant_vld && !grant_id;
  assign bus.req1_ready_o = reset_n && grant_vld && grant_id;

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    id_d              = id_q;
    rsp_valid_d       = 2'b00;
    rsp_err_d         = 2'b00;
    dmem_req_d        = 1'b0;
    dmem_addr_d       = '0;
    dmem_byte_en_d    = '0;
    dmem_wr_d         = 1'b0;
    dmem_wr_data_d    = '0;
    dmem_zero_extnd_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          id_d         = grant_id;
          last_grant_d = grant_id;
          if (sel_legal) begin
            state_d           = ISSUE;
            dmem_req_d        = 1'b1;
            dmem_addr_d       = sel_addr;
            dmem_byte_en_d    = sel_byte_en;
            dmem_wr_d         = sel_wr;
            dmem_wr_data_d    = sel_wr_data;
            dmem_zero_extnd_d = sel_zero_extnd;
            rsp_valid_d[grant_id] = sel_wr;
          end else begin
            state_d               = ERR;
            rsp_valid_d[grant_id] = 1'b1;
            rsp_err_d[grant_id]   = 1'b1;
          end
        end
      end
      ISSUE: begin
        // Loads hold the request so the memory's output extraction sees stable controls.
        if (dmem_wr_q) begin
          state_d = IDLE;
        end else begin
          state_d           = RESP;
          dmem_req_d        = 1'b1;
          dmem_addr_d       = dmem_addr_q;
          dmem_byte_en_d    = dmem_byte_en_q;
          dmem_wr_data_d    = dmem_wr_data_q;
          dmem_zero_extnd_d = dmem_zero_extnd_q;
          rsp_valid_d[id_q] = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      last_grant_q      <= 1'b1;
      id_q              <= 1'b0;
      rsp_valid_q       <= 2'b00;
      rsp_err_q         <= 2'b00;
      dmem_req_q        <= 1'b0;
      dmem_addr_q       <= '0;
      dmem_byte_en_q    <= '0;
      dmem_wr_q         <= 1'b0;
      dmem_wr_data_q    <= '0;
      dmem_zero_extnd_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      id_q              <= id_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_err_q         <= rsp_err_d;
      dmem_req_q        <= dmem_req_d;
      dmem_addr_q       <= dmem_addr_d;
      dmem_byte_en_q    <= dmem_byte_en_d;
      dmem_wr_q         <= dmem_wr_d;
      dmem_wr_data_q    <= dmem_wr_data_d;
      dmem_zero_extnd_q <= dmem_zero_extnd_d;
    end
  end

  // Load data arrives from memory in the RESP cycle itself, so it is passed through.
  logic [31:0] load_data;
  assign load_data = (state_q == RESP) ? bus.dmem_rd_data_i : '0;

  assign bus.rsp0_valid_o      = rsp_valid_q[0];
  assign bus.rsp0_err_o        = rsp_err_q[0];
  assign bus.rsp0_rd_data_o    = id_q ? '0 : load_data;
  assign bus.rsp1_valid_o      = rsp_valid_q[1];
  assign bus.rsp1_err_o        = rsp_err_q[1];
  assign bus.rsp1_rd_data_o    = id_q ? load_data : '0;
  assign bus.dmem_req_o        = dmem_req_q;
  assign bus.dmem_addr_o       = dmem_addr_q;
  assign bus.dmem_byte_en_o    = dmem_byte_en_q;
  assign bus.dmem_wr_o         = dmem_wr_q;
  assign bus.dmem_wr_data_o    = dmem_wr_data_q;
  assign bus.dmem_zero_extnd_o = dmem_zero_extnd_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, randomized traffic against a
// byte-level transaction model, plus reset-in-flight and contention sequences.
module tb_dmem_arbiter;
  localparam int DMEM_WORDS = 1024;

  logic clk;
  logic reset_n;
  dmem_arbiter_if bus ();

  dmem_arbiter #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  be;
    logic        wr;
    logic [31:0] wdata;
    logic        zx;
  } req_t;

  typedef struct {
    int          port;
    req_t        req;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory model: registers the addressed word on the request edge and extracts
  // combinationally from the address/size/sign controls held in the next cycle.
  logic [31:0] mem_words [DMEM_WORDS];
  logic [31:0] rd_word;

  function automatic logic [31:0] extract(logic [31:0] w, logic [31:0] a, logic [1:0] be, logic zx);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a[1:0]));
    h = 16'(w >> (16 * a[1]));
    case (be)
      2'b00:   return zx ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return zx ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign bus.dmem_rd_data_i = extract(rd_word, bus.dmem_addr_o, bus.dmem_byte_en_o, bus.dmem_zero_extnd_o);

  always @(posedge clk) begin
    if (bus.dmem_req_o) begin
      if (bus.dmem_wr_o) begin
        case (bus.dmem_byte_en_o)
          2'b00:   mem_words[bus.dmem_addr_o[11:2]][8*bus.dmem_addr_o[1:0] +: 8] = bus.dmem_wr_data_o[7:0];
          2'b01:   mem_words[bus.dmem_addr_o[11:2]][16*bus.dmem_addr_o[1] +: 16] = bus.dmem_wr_data_o[15:0];
          default: mem_words[bus.dmem_addr_o[11:2]] = bus.dmem_wr_data_o;
        endcase
      end
      rd_word <= mem_words[bus.dmem_addr_o[11:2]];
    end
  end

  // Reference model: flat byte array and the access rules written arithmetically.
  logic [7:0] model_mem [4*DMEM_WORDS];

  function automatic int access_size(logic [1:0] be);
    case (be)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_legal(logic [31:0] addr, logic [1:0] be);
    int size;
    size = access_size(be);
    if (size == 0) return 1'b0;
    if ((addr % 32'(size)) != 0) return 1'b0;
    return addr < 32'(4 * DMEM_WORDS);
  endfunction

  task automatic model_store(req_t r);
    for (int i = 0; i < access_size(r.be); i++)
      model_mem[int'(r.addr) + i] = r.wdata[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(req_t r);
    int size;
    logic [31:0] v;
    size = access_size(r.be);
    v = 32'h0;
    for (int i = 0; i < size; i++)
      v = v | (32'(model_mem[int'(r.addr) + i]) << (8 * i));
    if (size < 4 && !r.zx && v[8*size-1])
      v = v | ~((32'h1 << (8 * size)) - 32'h1);
    return v;
  endfunction

  task automatic clear_memories();
    for (int i = 0; i < DMEM_WORDS; i++) mem_words[i] = 32'h0;
    for (int i = 0; i < 4*DMEM_WORDS; i++) model_mem[i] = 8'h0;
  endtask

  task automatic check_output(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive_port(int p, bit v, req_t r);
    if (p == 0) begin
      bus.req0_valid_i = v; bus.req0_addr_i = r.addr; bus.req0_byte_en_i = r.be;
      bus.req0_wr_i = r.wr; bus.req0_wr_data_i = r.wdata; bus.req0_zero_extnd_i = r.zx;
    end else begin
      bus.req1_valid_i = v; bus.req1_addr_i = r.addr; bus.req1_byte_en_i = r.be;
      bus.req1_wr_i = r.wr; bus.req1_wr_data_i = r.wdata; bus.req1_zero_extnd_i = r.zx;
    end
  endtask

  function automatic logic [1:0] get_ready();
    return {bus.req1_ready_o, bus.req0_ready_o};
  endfunction

  function automatic logic [33:0] get_rsp(int p);
    if (p == 0) return {bus.rsp0_valid_o, bus.rsp0_err_o, bus.rsp0_rd_data_o};
    return {bus.rsp1_valid_o, bus.rsp1_err_o, bus.rsp1_rd_data_o};
  endfunction

  function automatic logic [4:0] get_dctl();
    return {bus.dmem_req_o, bus.dmem_wr_o, bus.dmem_byte_en_o, bus.dmem_zero_extnd_o};
  endfunction

  task automatic check_all_zero(string name);
    check_output({name, "_ctl"}, 64'({get_ready(), get_rsp(0)[33:32], get_rsp(1)[33:32], get_dctl()}), 64'h0);
    check_output({name, "_data"}, {bus.rsp0_rd_data_o, bus.rsp1_rd_data_o}, 64'h0);
    check_output({name, "_dmem"}, {bus.dmem_addr_o, bus.dmem_wr_data_o}, 64'h0);
  endtask

  task automatic do_reset();
    req_t z;
    z = '{default: '0};
    @(negedge clk);
    reset_n = 1'b0;
    drive_port(0, 1'b0, z);
    drive_port(1, 1'b0, z);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One directed access on a single port with cycle-exact response checks.
  task automatic apply_stimulus(vec_t v);
    req_t z;
    logic [4:0] exp_dctl;
    z = '{default: '0};
    @(negedge clk);
    drive_port(v.port, 1'b1, v.req);
    drive_port(1 - v.port, 1'b0, z);
    #1;
    check_output("vec_ready", 64'(get_ready()), 64'(2'b01 << v.port));
    @(posedge clk);
    @(negedge clk);
    drive_port(v.port, 1'b0, z);
    #1;
    check_output("vec_rsp_other", 64'(get_rsp(1 - v.port)), 64'h0);
    if (v.exp_err) begin
      check_output("vec_err_rsp", 64'(get_rsp(v.port)), 64'({2'b11, 32'h0}));
      check_output("vec_err_dmem", 64'(get_dctl()), 64'h0);
    end else begin
      exp_dctl = {1'b1, v.req.wr, v.req.be, v.req.zx};
      check_output("vec_issue_dmem", 64'(get_dctl()), 64'(exp_dctl));
      check_output("vec_issue_addr", 64'(bus.dmem_addr_o), 64'(v.req.addr));
      if (v.req.wr) begin
        check_output("vec_store_rsp", 64'(get_rsp(v.port)), 64'({2'b10, 32'h0}));
        check_output("vec_store_wdata", 64'(bus.dmem_wr_data_o), 64'(v.req.wdata));
      end else begin
        check_output("vec_issue_norsp", 64'(get_rsp(v.port)), 64'h0);
        @(negedge clk);
        #1;
        check_output("vec_load_rsp", 64'(get_rsp(v.port)), 64'({2'b10, v.exp_rdata}));
        check_output("vec_resp_dmem", 64'(get_dctl()), 64'({1'b1, 1'b0, v.req.be, v.req.zx}));
        check_output("vec_resp_addr", 64'(bus.dmem_addr_o), 64'(v.req.addr));
        check_output("vec_resp_other", 64'(get_rsp(1 - v.port)), 64'h0);
      end
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    int sel;
    sel = $urandom_range(0, 9);
    r.be = 2'($urandom_range(0, 3));
    if (sel == 0)      r.addr = 32'h1000 + 32'($urandom_range(0, 15));
    else if (sel == 1) r.addr = 32'hFF8 + 32'($urandom_range(0, 7));
    else if (sel == 2) r.addr = $urandom;
    else               r.addr = 32'($urandom_range(0, 31));
    if (sel >= 3 && $urandom_range(0, 1) == 1) r.addr = r.addr & ~32'h3;
    r.wr    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    r.zx    = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Random traffic; the model predicts grants and response timing from
  // accept cycle + fixed latency, independent of the RTL state machine.
  task automatic run_random(int cycles);
    req_t pend_req [2];
    bit   pend [2];
    int   free_at, winner, age;
    bit   lg, accept;
    bit   t_on, t_port, t_err, t_load;
    int   t_acc;
    req_t t;
    logic [31:0] t_data;
    logic [1:0]  exp_ready;
    logic [33:0] exp_rsp [2];
    logic [4:0]  exp_dctl;
    logic [31:0] exp_addr, exp_wdata;
    bit          chk_wdata;
    free_at = 0; lg = 1'b1; t_on = 1'b0; t_acc = 0; t_port = 0; t_err = 0; t_load = 0;
    t = '{default: '0}; t_data = '0;
    pend[0] = 0; pend[1] = 0;
    pend_req[0] = '{default: '0}; pend_req[1] = '{default: '0};
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 45) begin
          pend_req[p] = rand_req();
          pend[p] = 1'b1;
        end
        drive_port(p, pend[p], pend_req[p]);
      end
      #1;
      exp_ready = 2'b00; accept = 1'b0; winner = 0;
      if (cyc >= free_at && (pend[0] || pend[1])) begin
        winner = (pend[0] && pend[1]) ? int'(!lg) : int'(pend[1]);
        exp_ready[winner] = 1'b1;
        accept = 1'b1;
      end
      exp_rsp[0] = '0; exp_rsp[1] = '0;
      exp_dctl = '0; exp_addr = '0; exp_wdata = '0; chk_wdata = 1'b1;
      if (t_on) begin
        age = cyc - t_acc;
        if (t_err) begin
          if (age == 1) exp_rsp[t_port] = {2'b11, 32'h0};
        end else if (!t_load) begin
          if (age == 1) begin
            exp_rsp[t_port] = {2'b10, 32'h0};
            exp_dctl = {1'b1, 1'b1, t.be, t.zx};
            exp_addr = t.addr;
            exp_wdata = t.wdata;
          end
        end else begin
          if (age == 1 || age == 2) begin
            exp_dctl = {1'b1, 1'b0, t.be, t.zx};
            exp_addr = t.addr;
            chk_wdata = 1'b0;
          end
          if (age == 2) exp_rsp[t_port] = {2'b10, t_data};
        end
      end
      check_output("rnd_ready", 64'(get_ready()), 64'(exp_ready));
      check_output("rnd_rsp0", 64'(get_rsp(0)), 64'(exp_rsp[0]));
      check_output("rnd_rsp1", 64'(get_rsp(1)), 64'(exp_rsp[1]));
      check_output("rnd_dctl", 64'(get_dctl()), 64'(exp_dctl));
      check_output("rnd_daddr", 64'(bus.dmem_addr_o), 64'(exp_addr));
      if (chk_wdata) check_output("rnd_dwdata", 64'(bus.dmem_wr_data_o), 64'(exp_wdata));
      if (accept) begin
        t = pend_req[winner];
        t_on = 1'b1; t_acc = cyc; t_port = 1'(winner);
        t_err = !is_legal(t.addr, t.be);
        t_load = !t.wr;
        if (!t_err) begin
          if (t.wr) model_store(t);
          else t_data = model_load(t);
        end
        free_at = cyc + ((t_load && !t_err) ? 3 : 2);
        lg = 1'(winner);
        pend[winner] = 1'b0;
      end
    end
  endtask

  vec_t vecs [16];
  req_t st0, st1, ld0;
  int   w;

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    st0 = '{default: '0};
    drive_port(0, 1'b0, st0);
    drive_port(1, 1'b0, st0);
    clear_memories();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    vecs[0]  = '{0, '{32'h10,  2'b11, 1'b1, 32'hDEADBEEF, 1'b0}, 1'b0, 32'h0};
    vecs[1]  = '{0, '{32'h10,  2'b11, 1'b0, 32'h0,        1'b0}, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1, '{32'h10,  2'b11, 1'b1, 32'h80000000, 1'b0}, 1'b0, 32'h0};
    vecs[3]  = '{1, '{32'h13,  2'b00, 1'b0, 32'h0,        1'b0}, 1'b0, 32'hFFFFFF80};
    vecs[4]  = '{1, '{32'h13,  2'b00, 1'b0, 32'h0,        1'b1}, 1'b0, 32'h00000080};
    vecs[5]  = '{0, '{32'h12,  2'b01, 1'b0, 32'h0,        1'b0}, 1'b0, 32'hFFFF8000};
    vecs[6]  = '{0, '{32'h14,  2'b01, 1'b1, 32'hABCD1234, 1'b0}, 1'b0, 32'h0};
    vecs[7]  = '{1, '{32'h14,  2'b11, 1'b0, 32'h0,        1'b0}, 1'b0, 32'h00001234};
    vecs[8]  = '{0, '{32'h02,  2'b11, 1'b1, 32'h11111111, 1'b0}, 1'b1, 32'h0};
    vecs[9]  = '{1, '{32'h01,  2'b01, 1'b0, 32'h0,        1'b0}, 1'b1, 32'h0};
    vecs[10] = '{0, '{32'h18,  2'b10, 1'b1, 32'h22222222, 1'b0}, 1'b1, 32'h0};
    vecs[11] = '{1, '{32'h1000, 2'b00, 1'b1, 32'h000000FF, 1'b0}, 1'b1, 32'h0};
    vecs[12] = '{0, '{32'h10,  2'b11, 1'b0, 32'h0,        1'b0}, 1'b0, 32'h80000000};
    vecs[13] = '{1, '{32'hFFF, 2'b00, 1'b0, 32'h0,        1'b1}, 1'b0, 32'h0};
    vecs[14] = '{0, '{32'h18,  2'b11, 1'b0, 32'h0,        1'b0}, 1'b0, 32'h0};
    vecs[15] = '{1, '{32'h00,  2'b11, 1'b0, 32'h0,        1'b0}, 1'b0, 32'h0};
    for (int i = 0; i < 16; i++) apply_stimulus(vecs[i]);

    do_reset();
    clear_memories();
    run_random(1500);

    // Reset while a load sits in RESP: everything drops at once, no response follows.
    do_reset();
    ld0 = '{32'h10, 2'b11, 1'b0, 32'h0, 1'b0};
    st0 = '{32'h20, 2'b11, 1'b1, 32'hA5A5A5A5, 1'b0};
    st1 = '{32'h24, 2'b11, 1'b1, 32'h5A5A5A5A, 1'b0};
    @(negedge clk);
    drive_port(0, 1'b1, ld0);
    #1;
    check_output("rst_ld_ready", 64'(get_ready()), 64'h1);
    @(posedge clk);
    @(negedge clk);
    drive_port(0, 1'b0, ld0);
    @(posedge clk);
    #1;
    check_output("rst_in_resp", 64'({bus.rsp0_valid_o, bus.dmem_req_o}), 64'h3);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    #1;
    check_all_zero("rst_held");
    drive_port(0, 1'b1, st0);
    drive_port(1, 1'b1, st1);
    reset_n = 1'b1;

    // Continuous contention with stores: grants alternate starting at port 0.
    w = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (k % 2 == 0) begin
        check_output("cont_ready", 64'(get_ready()), 64'(2'b01 << w));
        check_output("cont_idle_rsp", 64'({bus.rsp1_valid_o, bus.rsp0_valid_o}), 64'h0);
      end else begin
        check_output("cont_busy_ready", 64'(get_ready()), 64'h0);
        check_output("cont_rsp", 64'({bus.rsp1_valid_o, bus.rsp0_valid_o}), 64'(2'b01 << w));
        w = 1 - w;
      end
      @(negedge clk);
    end
    drive_port(0, 1'b0, st0);
    drive_port(1, 1'b0, st1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the data memory. Shares the single 4 KB data memory between requester 0 (core load/store path) and requester 1 (debug/DMA port). Uses round-robin arbitration and rejects illegal accesses (reserved size, misaligned, out of range) without touching memory. Sequences each access to match the memory's timing: read data is registered one cycle after the request, and the memory's output extraction requires address, size and sign control to stay stable in the response cycle.

## Interface
- DMEM_WORDS, 1024, memory depth in 32-bit words; legal byte addresses are 0 .. 4*DMEM_WORDS-1.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reqN_valid_i  in  1  request N valid (N = 0, 1; every reqN_/rspN_ port exists per requester).
- reqN_ready_o  out  1  request N accepted this cycle when valid && ready.
- reqN_addr_i  in  32  byte address.
- reqN_byte_en_i  in  2  access size: 00 byte, 01 half-word, 10 reserved, 11 word.
- reqN_wr_i  in  1  1 = store, 0 = load.
- reqN_wr_data_i  in  32  store data, right-aligned.
- reqN_zero_extnd_i  in  1  1 = zero-extend load, 0 = sign-extend.
- rspN_valid_o  out  1  one-cycle response pulse.
- rspN_err_o  out  1  response is an error; qualified by rspN_valid_o.
- rspN_rd_data_o  out  32  load data; 0 for stores and errors.
- dmem_req_o, dmem_addr_o[31:0], dmem_byte_en_o[1:0], dmem_wr_o, dmem_wr_data_o[31:0], dmem_zero_extnd_o  out  memory-side request, all registered.
- dmem_rd_data_i  in  32  memory read data, already extracted and extended.

## Operation
- FSM states: IDLE, ISSUE, RESP, ERR. Reset state is IDLE.
- IDLE: reqN_ready_o is combinational; it is 1 only for the arbitration winner, and only when that requester's valid is 1.
  - Winner selection: if exactly one requester is valid, it wins.
  - If both are valid, the winner is the requester not in last_grant.
  - last_grant resets to 1, so port 0 wins the first tie.
- On accept:
  - Capture addr, byte_en, wr, wr_data, zero_extnd and the requester id; update last_grant.
  - If the legality check passes, go to ISSUE; otherwise go to ERR.
- Legality check fails on any of:
  - byte_en == 10.
  - Half-word access with addr[0] == 1.
  - Word access with addr[1:0] != 00.
  - addr >= 4*DMEM_WORDS.
- ISSUE:
  - Drive dmem_req_o = 1 with the captured fields; dmem_wr_o = captured wr.
  - Store: pulse rspN_valid_o (err 0, data 0), then go to IDLE.
  - Load: go to RESP.
- RESP:
  - Hold dmem_req_o = 1 with the same addr, byte_en and zero_extnd; force dmem_wr_o = 0 so no second write can occur.
  - Pulse rspN_valid_o with rspN_rd_data_o = dmem_rd_data_i, then go to IDLE.
- ERR: dmem_req_o = 0; pulse rspN_valid_o with rspN_err_o = 1 and data 0, then go to IDLE.
- In IDLE and ERR all dmem_* outputs are 0.
- Responses have no backpressure; requesters must sample the pulse.
- Requesters hold valid and payload stable until ready; a loser's request stays pending and wins the next IDLE cycle.
- Only the granted requester's rsp pulses; the other's rsp outputs stay 0.

## Timing
- Reset (asynchronous assert): state IDLE, last_grant 1, all outputs 0 (ready, rsp valid/err/data, all dmem_*).
  - An in-flight access is dropped with no response.
  - A store issued in the same edge as reset is not guaranteed.
- Accept in cycle T:
  - Store: dmem_req in T+1, response in T+1, next accept possible in T+2.
  - Load: dmem_req in T+1 and T+2, response in T+2, next accept in T+3.
  - Error: response in T+1, no dmem_req, next accept in T+2.
- Throughput: one store per 2 cycles, one load per 3 cycles.
- Under continuous contention from both ports, grants strictly alternate.
- No request is accepted while the FSM is outside IDLE; ready is 0 there.
- Requester valid dropping before ready is a protocol violation. No check is required; the arbiter simply re-arbitrates.

## Test plan
- Port 0 word store addr 0x10 data 0xDEADBEEF at T, then word load addr 0x10 -> rsp0_valid at T+1 (err 0); load response 0xDEADBEEF two cycles after its accept; dmem_wr_o 0 in RESP.
- Port 1 byte load addr 0x13, zero_extnd 0, after storing 0x80000000 to 0x10 -> rsp1_rd_data 0xFFFFFF80; same with zero_extnd 1 -> 0x00000080; dmem_addr/byte_en identical in ISSUE and RESP.
- Both ports valid continuously with stores -> first grant port 0, then strict alternation 1,0,1...; each ready is a one-cycle pulse; no response ever on the non-granted port.
- Illegal requests: word at 0x02, half-word at 0x01, byte_en 10, byte at 0x1000 with DMEM_WORDS 1024 -> rsp_err 1 one cycle after accept, dmem_req never asserted, memory contents unchanged.
- reset_n asserted during RESP of a load -> all outputs 0 immediately, no rsp pulse, next tie after release granted to port 0.
